// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state type and default sizing for the stream serializer
package seq_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/seq_word_fifo.sv
// seq_word_fifo: word FIFO with extra-MSB pointers to tell full from empty
module seq_word_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];
  // pointer update; a push and a pop on the same edge leave occupancy unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end
  // storage needs no reset: emptiness is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/seq_stream_serializer.sv
// seq_stream_serializer: buffers parallel words and shifts them out one bit per cycle
module seq_stream_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             idle
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  state_t           state, next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr, head;
  logic             full, empty, pop, boundary;
  seq_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  assign in_ready    = !full;
  assign ser_valid   = state == SHIFT;
  assign frame_start = ser_valid && cnt == '0;
  assign ser_data    = ser_valid && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
  assign idle        = state == IDLE && empty;
  // a word boundary (idle, or last bit) is where the next word is pulled from the FIFO
  always_comb begin
    boundary = state == IDLE || cnt == LAST;
    pop      = boundary && !empty;
    next     = boundary ? (empty ? IDLE : SHIFT) : state;
  end
  // state, bit counter and shifter; a reload on the last bit keeps frames gapless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= next;
      if (pop) begin
        sr  <= head;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        cnt <= cnt == LAST ? '0 : cnt + CW'(1);
      end
    end
  end
  a_quiet_data: assert property (@(posedge clk) disable iff (!rst) ser_valid || !ser_data);
  a_fs_valid:   assert property (@(posedge clk) disable iff (!rst) !frame_start || ser_valid);
  c_b2b_frames: cover property (@(posedge clk) disable iff (!rst) state == SHIFT && cnt == LAST && pop);
endmodule

// File: tb/tb_seq_stream_serializer.sv
// tb_seq_stream_serializer: scoreboard bench for MSB-first and LSB-first serializers
module tb_seq_stream_serializer;
  logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       m_rdy, m_data, m_v, m_fs, m_idle;
  logic       l_rdy, l_data, l_v, l_fs, l_idle;
  typedef struct {logic [7:0] data; logic [7:0] lsb_stream;} vec_t;
  vec_t       tbl [9];
  int         vectors = 0, miscompares = 0;
  logic [1:0] qm [$], ql [$];
  bit         saw_stall;

  always #5 clk = ~clk;

  seq_stream_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_rdy),
    .ser_data(m_data), .ser_valid(m_v), .frame_start(m_fs), .idle(m_idle)
  );
  seq_stream_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_rdy),
    .ser_data(l_data), .ser_valid(l_v), .frame_start(l_fs), .idle(l_idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      if (m_v) begin
        if (qm.size() == 0) chk("msb_extra_bit", 1, 0);
        else begin
          e = qm.pop_front();
          chk("msb_bit", m_data, e[1]);
          chk("msb_fs", m_fs, e[0]);
        end
      end else if (m_data || m_fs) chk("msb_quiet", {m_data, m_fs}, 0);
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      if (l_v) begin
        if (ql.size() == 0) chk("lsb_extra_bit", 1, 0);
        else begin
          e = ql.pop_front();
          chk("lsb_bit", l_data, e[1]);
          chk("lsb_fs", l_fs, e[0]);
        end
      end else if (l_data || l_fs) chk("lsb_quiet", {l_data, l_fs}, 0);
    end
  end

  task automatic send(input int k);
    int w = 0;
    in_valid = 1'b1;
    in_data  = tbl[k].data;
    while (!m_rdy && w < 200) begin
      saw_stall = 1'b1;
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("send_timeout", 0, 1);
    for (int i = 0; i < 8; i++) begin
      qm.push_back({tbl[k].data[7-i], i == 0});
      ql.push_back({tbl[k].lsb_stream[7-i], i == 0});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while (!(qm.size() == 0 && ql.size() == 0 && m_idle && l_idle) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_q", qm.size() + ql.size(), 0);
    chk("drain_idle", {m_idle, l_idle}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w;
    logic [31:0] fsv;
    tbl[0] = '{8'hA6, 8'h65};
    tbl[1] = '{8'h5C, 8'h3A};
    tbl[2] = '{8'h01, 8'h80};
    tbl[3] = '{8'hFF, 8'hFF};
    tbl[4] = '{8'h00, 8'h00};
    tbl[5] = '{8'h80, 8'h01};
    tbl[6] = '{8'h3C, 8'h3C};
    tbl[7] = '{8'hC3, 8'hC3};
    tbl[8] = '{8'h12, 8'h48};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", m_rdy, 1);
    chk("rst_ser_valid", m_v, 0);
    chk("rst_ser_data", m_data, 0);
    chk("rst_frame_start", m_fs, 0);
    chk("rst_idle", {m_idle, l_idle}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    send(0);
    in_valid = 1'b0;
    chk("lat_edge1_valid", m_v, 0);
    chk("lat_edge1_idle", m_idle, 0);
    @(negedge clk);
    chk("lat_edge2_valid", m_v, 1);
    chk("lat_edge2_fs", m_fs, 1);
    drain();
    send(0);
    send(1);
    in_valid = 1'b0;
    w = 0;
    while (!m_v && w < 20) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    fsv = '0;
    while (m_v && n < 32) begin
      fsv[n] = m_fs;
      n++;
      @(negedge clk);
    end
    chk("b2b_len", n, 16);
    chk("b2b_fs_pos", fsv, 32'h101);
    drain();
    saw_stall = 1'b0;
    for (int k = 0; k < 6; k++) send(k);
    drain();
    chk("stall_seen", saw_stall, 1);
    for (int k = 0; k < 9; k++) begin
      send(k);
      in_valid = 1'b0;
      repeat (k) @(negedge clk);
    end
    drain();
    send(2);
    send(3);
    send(4);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_word_valid", m_v, 1);
    rst = 1'b0;
    #1;
    chk("async_in_ready", m_rdy, 1);
    chk("async_ser_valid", m_v, 0);
    chk("async_ser_data", m_data, 0);
    chk("async_frame_start", m_fs, 0);
    chk("async_idle", m_idle, 1);
    qm.delete();
    ql.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {m_idle, m_v}, 2'b10);
    send(3);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
